// File: rtl/pipe_pkg.sv
// Shared pipeline types: shadow-pipe entry, forwarding select constants, latency clamp.
// Entry fields are sized for REG_AW <= 8 and FWD_STAGES <= 15.
package pipe_pkg;

    localparam int ENT_RD_W   = 8;
    localparam int ENT_LAT_W  = 4;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic [ENT_RD_W-1:0]  rd;
        logic [ENT_LAT_W-1:0] lat;
    } entry_t;

    // A result is never available before M, nor later than the last tracked stage.
    function automatic logic [ENT_LAT_W-1:0] clamp_lat(input logic [ENT_LAT_W-1:0] lat,
                                                       input int max_lat);
        int l;
        l = int'(lat);
        if (l == 0) l = 1;
        if (l > max_lat) l = max_lat;
        return ENT_LAT_W'(l);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-source lookup over the shadow pipe: youngest matching producer stage,
// hit flag, and whether that producer's result arrives too late for E.
module hazard_match
    import pipe_pkg::*;
#(
    parameter  int FWD_STAGES = 2,
    parameter  int REG_AW     = 5,
    localparam int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              used,
    input  entry_t            pipe [0:FWD_STAGES],
    output logic              hit,
    output logic [SEL_W-1:0]  stage,
    output logic              hazard
);

    // Scan oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        hit    = 1'b0;
        stage  = '0;
        hazard = 1'b0;
        for (int s = FWD_STAGES; s >= 0; s--) begin
            if (used && (rs != '0) && pipe[s].valid && pipe[s].regwrite &&
                (pipe[s].rd == ENT_RD_W'(rs))) begin
                hit    = 1'b1;
                stage  = SEL_W'(s);
                hazard = (s + 1) < int'(pipe[s].lat);
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Operand forwarding select and load-use stall control over FWD_STAGES post-E stages.
// Optional HAZARD_PERF_EN adds saturating stall / forward counters.
module hazard_forward_ctrl
    import pipe_pkg::*;
#(
    parameter  int NUM_SRC    = 2,
    parameter  int FWD_STAGES = 2,
    parameter  int REG_AW     = 5,
    localparam int SEL_W      = $clog2(FWD_STAGES + 1),
    localparam int LAT_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      d_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] d_rs_i,
    input  logic [NUM_SRC-1:0]        d_rs_used_i,
    input  logic [REG_AW-1:0]         d_rd_i,
    input  logic                      d_regwrite_i,
    input  logic [LAT_W-1:0]          d_lat_i,
    input  logic                      flush_i,
    output logic                      stall_d_o,
    output logic                      e_valid_o,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_e_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]               stall_cnt_o,
    output logic [31:0]               fwd_cnt_o
`endif
);

    entry_t                   pipe [0:FWD_STAGES];
    logic [NUM_SRC-1:0]       hit;
    logic [NUM_SRC-1:0]       haz;
    logic [SEL_W-1:0]         stage [NUM_SRC];
    logic [NUM_SRC*SEL_W-1:0] sel_n;
    logic                     issue;

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
        hazard_match #(
            .FWD_STAGES (FWD_STAGES),
            .REG_AW     (REG_AW)
        ) u_match (
            .rs     (d_rs_i[j*REG_AW +: REG_AW]),
            .used   (d_rs_used_i[j]),
            .pipe   (pipe),
            .hit    (hit[j]),
            .stage  (stage[j]),
            .hazard (haz[j])
        );
    end

    assign stall_d_o = ~rst & d_valid_i & ~flush_i & (|haz);
    assign issue     = d_valid_i & ~stall_d_o & ~flush_i;
    assign e_valid_o = pipe[0].valid;

    // A producer already in W is covered by the write-first register file.
    always_comb begin
        sel_n = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            sel_n[j*SEL_W +: SEL_W] = SEL_W'(FWD_SEL_RF);
            if (issue && hit[j] && (stage[j] < SEL_W'(FWD_STAGES))) begin
                sel_n[j*SEL_W +: SEL_W] = stage[j] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= FWD_STAGES; s++) begin
                pipe[s] <= '0;
            end
            fwd_sel_e_o <= '0;
        end else begin
            pipe[0] <= '0;
            if (issue) begin
                pipe[0].valid    <= 1'b1;
                pipe[0].regwrite <= d_regwrite_i;
                pipe[0].rd       <= ENT_RD_W'(d_rd_i);
                pipe[0].lat      <= clamp_lat(ENT_LAT_W'(d_lat_i), FWD_STAGES);
            end
            for (int s = 1; s <= FWD_STAGES; s++) begin
                pipe[s] <= pipe[s-1];
            end
            fwd_sel_e_o <= sel_n;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            fwd_cnt_o   <= '0;
        end else begin
            if (stall_d_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
            if ((|sel_n) && (fwd_cnt_o != '1))    fwd_cnt_o   <= fwd_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl (NUM_SRC=2, FWD_STAGES=2): directed scenarios plus
// randomized traffic against an issue-history model; honours HAZARD_PERF_EN.
module tb_hazard_forward_ctrl;

    localparam int FS = 2;

    logic       clk;
    logic       rst;
    logic       d_valid_i;
    logic [9:0] d_rs_i;
    logic [1:0] d_rs_used_i;
    logic [4:0] d_rd_i;
    logic       d_regwrite_i;
    logic [1:0] d_lat_i;
    logic       flush_i;
    logic       stall_d_o;
    logic       e_valid_o;
    logic [3:0] fwd_sel_e_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] fwd_cnt_o;
`endif

    hazard_forward_ctrl #(.NUM_SRC(2), .FWD_STAGES(FS), .REG_AW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .d_valid_i    (d_valid_i),
        .d_rs_i       (d_rs_i),
        .d_rs_used_i  (d_rs_used_i),
        .d_rd_i       (d_rd_i),
        .d_regwrite_i (d_regwrite_i),
        .d_lat_i      (d_lat_i),
        .flush_i      (flush_i),
        .stall_d_o    (stall_d_o),
        .e_valid_o    (e_valid_o),
        .fwd_sel_e_o  (fwd_sel_e_o)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .fwd_cnt_o    (fwd_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: every issued register-writing instruction with its issue cycle.
    typedef struct {
        int         cyc;
        logic [4:0] rd;
        int         lat;
    } rec_t;

    rec_t       hist[$];
    int         cur;
    int         errors;
    int         checks;
    int         m_stall_cnt;
    int         m_fwd_cnt;
    logic       exp_stall;
    logic       exp_issue;
    logic [3:0] exp_sel;
    logic       obs_stall;
    logic       obs_evalid;
    logic [3:0] obs_sel;

    function automatic int lat_eff(input int l);
        if (l == 0) return 1;
        if (l > FS) return FS;
        return l;
    endfunction

    // Distance d = cycles since the producer left Decode (1 = producer now in E).
    // It becomes forwardable once d >= lat; stage d-1 = FS is served by the register file.
    function automatic void model_eval();
        logic       any_haz;
        logic [3:0] sel;
        logic [4:0] rs;
        int         d;
        any_haz = 1'b0;
        sel     = '0;
        for (int j = 0; j < 2; j++) begin
            rs = d_rs_i[j*5 +: 5];
            if (d_rs_used_i[j] && rs != 5'd0) begin
                for (int k = hist.size() - 1; k >= 0; k--) begin
                    if (hist[k].rd == rs) begin
                        d = cur - hist[k].cyc;
                        if (d <= FS + 1) begin
                            if (d < hist[k].lat) any_haz = 1'b1;
                            if (d <= FS) sel[j*2 +: 2] = 2'(d);
                        end
                        break;
                    end
                end
            end
        end
        exp_stall = d_valid_i && !flush_i && any_haz;
        exp_issue = d_valid_i && !flush_i && !exp_stall;
        exp_sel   = exp_issue ? sel : 4'd0;
    endfunction

    task automatic step(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic [4:0] rd, input logic rw,
                        input logic [1:0] lat, input logic fl);
        @(negedge clk);
        rst          = 1'b0;
        d_valid_i    = v;
        d_rs_i       = {rs1, rs0};
        d_rs_used_i  = used;
        d_rd_i       = rd;
        d_regwrite_i = rw;
        d_lat_i      = lat;
        flush_i      = fl;
        #1;
        model_eval();
        obs_stall = stall_d_o;
        @(posedge clk);
        if (exp_issue && rw) hist.push_back('{cur, rd, lat_eff(int'(lat))});
        if (exp_stall) m_stall_cnt++;
        if (exp_issue && exp_sel != 4'd0) m_fwd_cnt++;
        cur++;
        #1;
        obs_evalid = e_valid_o;
        obs_sel    = fwd_sel_e_o;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        obs_stall = stall_d_o;
        @(posedge clk);
        hist.delete();
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
        cur++;
        #1;
        obs_evalid = e_valid_o;
        obs_sel    = fwd_sel_e_o;
    endtask

    task automatic test_reset();
        d_valid_i = 1'b1; d_rs_i = {5'd5, 5'd5}; d_rs_used_i = 2'b11;
        d_rd_i = 5'd5; d_regwrite_i = 1'b1; d_lat_i = 2'd2; flush_i = 1'b0;
        apply_reset();
        apply_reset();
        checks++;
        if (obs_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", obs_stall); end
        checks++;
        if (obs_evalid !== 1'b0) begin errors++; $display("FAIL reset_evalid: got %b want 0", obs_evalid); end
        checks++;
        if (obs_sel !== 4'd0) begin errors++; $display("FAIL reset_sel: got %h want 0", obs_sel); end
`ifdef HAZARD_PERF_EN
        checks++;
        if (stall_cnt_o !== 32'd0 || fwd_cnt_o !== 32'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt_o, fwd_cnt_o);
        end
`endif
    endtask

    task automatic test_alu_chain();
        apply_reset();
        step(1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 2'd1, 0);   // add x5,x1,x2
        step(1, 5'd5, 5'd7, 2'b11, 5'd6, 1, 2'd1, 0);   // sub x6,x5,x7
        checks++;
        if (obs_stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", obs_stall); end
        checks++;
        if (obs_evalid !== 1'b1 || obs_sel !== 4'b0001) begin
            errors++; $display("FAIL alu_sel: got v=%b sel=%h want v=1 sel=1", obs_evalid, obs_sel);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        step(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 2'd2, 0);   // lw x5
        step(1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 2'd1, 0);   // add x6,x5,x5
        checks++;
        if (obs_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", obs_stall); end
        checks++;
        if (obs_evalid !== 1'b0 || obs_sel !== 4'd0) begin
            errors++; $display("FAIL lu_bubble: got v=%b sel=%h want v=0 sel=0", obs_evalid, obs_sel);
        end
        step(1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 2'd1, 0);
        checks++;
        if (obs_stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b want 0", obs_stall); end
        checks++;
        if (obs_evalid !== 1'b1 || obs_sel !== 4'b1010) begin
            errors++; $display("FAIL lu_sel: got v=%b sel=%h want v=1 sel=a", obs_evalid, obs_sel);
        end
    endtask

    task automatic test_youngest();
        apply_reset();
        step(1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 2'd1, 0);
        step(1, 5'd3, 5'd4, 2'b11, 5'd5, 1, 2'd1, 0);
        step(1, 5'd5, 5'd0, 2'b11, 5'd8, 1, 2'd1, 0);   // add x8,x5,x0
        checks++;
        if (obs_sel !== 4'b0001) begin errors++; $display("FAIL youngest_sel: got %h want 1", obs_sel); end
        apply_reset();
        step(1, 5'd1, 5'd0, 2'b01, 5'd0, 1, 2'd2, 0);   // lw x0
        step(1, 5'd0, 5'd0, 2'b11, 5'd9, 1, 2'd1, 0);   // add x9,x0,x0
        checks++;
        if (obs_stall !== 1'b0 || obs_sel !== 4'd0 || obs_evalid !== 1'b1) begin
            errors++; $display("FAIL x0_dest: got st=%b v=%b sel=%h want st=0 v=1 sel=0", obs_stall, obs_evalid, obs_sel);
        end
    endtask

    task automatic test_distance3();
        apply_reset();
        step(1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 2'd1, 0);
        step(1, 5'd1, 5'd2, 2'b11, 5'd10, 1, 2'd1, 0);
        step(1, 5'd3, 5'd4, 2'b11, 5'd11, 1, 2'd1, 0);
        step(1, 5'd7, 5'd5, 2'b11, 5'd12, 1, 2'd1, 0);
        checks++;
        if (obs_sel !== 4'd0 || obs_evalid !== 1'b1) begin
            errors++; $display("FAIL dist3_sel: got v=%b sel=%h want v=1 sel=0", obs_evalid, obs_sel);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        step(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 2'd2, 0);
        step(1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 2'd1, 1);
        checks++;
        if (obs_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", obs_stall); end
        checks++;
        if (obs_evalid !== 1'b0 || obs_sel !== 4'd0) begin
            errors++; $display("FAIL flush_bubble: got v=%b sel=%h want v=0 sel=0", obs_evalid, obs_sel);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        step(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 2'd2, 0);   // lw x5 now in E
        d_valid_i = 1'b1; d_rs_i = {5'd5, 5'd5}; d_rs_used_i = 2'b11;
        apply_reset();
        step(1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 2'd1, 0);
        checks++;
        if (obs_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b want 0", obs_stall); end
        checks++;
        if (obs_sel !== 4'd0 || obs_evalid !== 1'b1) begin
            errors++; $display("FAIL rstmid_sel: got v=%b sel=%h want v=1 sel=0", obs_evalid, obs_sel);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d want 0", stall_cnt_o); end
`endif
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                apply_reset();
                checks++;
                if (obs_evalid !== 1'b0 || obs_sel !== 4'd0) begin
                    errors++; $display("FAIL rnd_reset: got v=%b sel=%h want 0/0", obs_evalid, obs_sel);
                end
            end else begin
                step($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
                checks++;
                if (obs_stall !== exp_stall) begin
                    errors++; $display("FAIL rnd_stall cyc %0d: got %b want %b", cur, obs_stall, exp_stall);
                end
                checks++;
                if (obs_evalid !== exp_issue || obs_sel !== exp_sel) begin
                    errors++; $display("FAIL rnd_e cyc %0d: got v=%b sel=%h want v=%b sel=%h",
                                       cur, obs_evalid, obs_sel, exp_issue, exp_sel);
                end
            end
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (stall_cnt_o !== 32'(m_stall_cnt) || fwd_cnt_o !== 32'(m_fwd_cnt)) begin
            errors++; $display("FAIL rnd_cnt: got %0d/%0d want %0d/%0d", stall_cnt_o, fwd_cnt_o, m_stall_cnt, m_fwd_cnt);
        end
`endif
    endtask

    initial begin
        errors = 0; checks = 0; cur = 0; m_stall_cnt = 0; m_fwd_cnt = 0;
        rst = 1'b1; d_valid_i = 1'b0; d_rs_i = '0; d_rs_used_i = '0;
        d_rd_i = '0; d_regwrite_i = 1'b0; d_lat_i = '0; flush_i = 1'b0;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_youngest();
        test_distance3();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Parametrised successor to the two-stage operand forwarding logic in the RISC-V pipeline. It keeps its own shadow of in-flight destination registers across FWD_STAGES post-execute stages. For every source operand of the instruction in Decode, it computes a registered forwarding select for Execute. It also raises a Decode stall when a producer with multi-cycle result latency (loads, multi-cycle ALU ops) cannot supply the value by the time the consumer reaches Execute. It sits between the Decode/Execute pipeline registers and the Execute operand muxes.

## Interface
- NUM_SRC, 2, source operands per instruction (1..3)
- FWD_STAGES, 2, tracked stages after E (index 1 = M … FWD_STAGES = W)
- REG_AW, 5, register address width
- SEL_W, $clog2(FWD_STAGES+1), forwarding select width (derived)
- LAT_W, $clog2(FWD_STAGES+1), producer latency field width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- d_valid_i  in  1  Decode holds a real instruction
- d_rs_i  in  NUM_SRC*REG_AW  source register addresses, src j at [j*REG_AW +: REG_AW]
- d_rs_used_i  in  NUM_SRC  source j is actually read
- d_rd_i  in  REG_AW  destination register
- d_regwrite_i  in  1  instruction writes rd
- d_lat_i  in  LAT_W  first stage index at which the result is forwardable (1 = ALU result in M, 2 = load result in W)
- flush_i  in  1  squash the Decode instruction (branch resolved in E)
- stall_d_o  out  1  hold F/D, insert bubble into E
- e_valid_o  out  1  E holds a real instruction
- fwd_sel_e_o  out  NUM_SRC*SEL_W  per-source select for E: 0 = register file, k = stage k result

## Operation
- Shadow pipe: entries 0..FWD_STAGES, each {valid, regwrite, rd, lat}. Entry 0 mirrors E. Every cycle entry s moves to s+1, and entry FWD_STAGES retires.
- Match for source j at stage s: d_rs_used_i[j], rs != 0, entry valid, regwrite, rd == rs. The youngest match (lowest s) wins; older matches are ignored.
- Hazard for source j: youngest match at s with s+1 < lat. The value is not forwardable when the consumer reaches E.
- stall_d_o = d_valid_i & ~flush_i & (any source hazard).
- Issue = d_valid_i & ~stall_d_o & ~flush_i. On issue, entry 0 loads {1, d_regwrite_i, d_rd_i, d_lat_i} and each fwd_sel_e_o[j] loads s+1 of its youngest match, or 0 when there is none.
- On no issue, entry 0 loads a bubble (valid = 0) and all selects load 0.
- d_lat_i = 0 is treated as 1. d_lat_i > FWD_STAGES is treated as FWD_STAGES.
- The register file is write-first. A producer in W (s = FWD_STAGES) forwarded as s+1 would fall outside the window, so matches at s = FWD_STAGES give select 0.
- rd = 0 never creates a match. An instruction never forwards to itself.
- flush_i has priority over stall: the bubble is inserted and stall_d_o = 0.

## Timing
- stall_d_o: combinational from registered shadow state and the d_* inputs, same cycle.
- fwd_sel_e_o and e_valid_o: registered, valid in the cycle the instruction occupies E (1-cycle latency from issue).
- Reset: all entries invalid, e_valid_o = 0, fwd_sel_e_o = 0, stall_d_o = 0 regardless of the d_* inputs while rst = 1.
- Reset asserted mid-operation: all in-flight producers are discarded. There are no forwards in the cycle after reset deasserts.
- A stall persists until the producer advances far enough. A lat = 2 producer in E adjacent to a dependent consumer gives exactly 1 stall cycle. With FWD_STAGES = 3 and lat = 3 it gives 2 stall cycles.

## Configuration
- HAZARD_PERF_EN defined:
  - adds output stall_cnt_o (32) counting cycles with stall_d_o = 1;
  - adds output fwd_cnt_o (32) counting issued instructions with any nonzero select;
  - both counters clear on rst and saturate at all ones.
- HAZARD_PERF_EN undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package pipe_pkg:
  - entry typedef {valid, regwrite, rd, lat};
  - FWD_SEL_RF = 0;
  - the latency-clamp function.
- One sub-module, hazard_match: one per source. It takes one rs and the shadow pipe, and returns youngest-match stage, hit, and hazard. It is instantiated NUM_SRC times.

## Test plan
- ALU chain, FWD_STAGES = 2: issue add x5 (lat 1), then sub x6,x5,x7 → no stall; E select src0 = 1, src1 = 0.
- Load-use: lw x5 (lat 2), then add x6,x5,x5 → stall_d_o = 1 for 1 cycle, bubble in E (e_valid_o = 0); then selects src0 = src1 = 2.
- Youngest wins: add x5; add x5; add x8,x5,x0 → src0 select = 1, not 2. An x0 destination producer is never forwarded.
- Distance 3: add x5, two unrelated instructions, then use x5 → select 0 (register file write-first).
- Flush during stall: lw x5 then a dependent instruction with flush_i = 1 → stall_d_o = 0, bubble in E, no select.
- Reset mid-stream: rst for one cycle with a lw x5 in E → next cycle, a dependent Decode instruction gives stall_d_o = 0 and select 0. With HAZARD_PERF_EN, stall_cnt_o = 0.
